// File: rtl/mem_stage_pkg.sv
// ============================================================================
// mem_stage_pkg : shared widths, control-bit indices and FSM encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    // Bit positions inside signals_MEM = {MemRead, MemWrite, RegWrite, spare}
    localparam int SIG_MEMREAD  = 3;
    localparam int SIG_MEMWRITE = 2;
    localparam int SIG_REGWRITE = 1;
    localparam int SIG_SPARE    = 0;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } state_e;

endpackage : mem_stage_pkg

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
// data_memory : 2^ADDR_W x DATA_W, synchronous write, registered read
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_memory
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately left unreset so data survives a pipeline reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule : data_memory

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : pipeline MEM stage with 2-cycle loads and write-back registers
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_EXE,
    input  logic [DATA_W-1:0] AluResult_EXE,
    input  logic [DATA_W-1:0] valueB_EXE,
    input  logic [2:0]        rd_EXE,
    input  logic [3:0]        signals_MEM,
    input  logic              flush,
    output logic              stall_MEM,
    output logic              valid_WB,
    output logic [DATA_W-1:0] result_WB,
    output logic [2:0]        rd_WB,
    output logic              RegWrite_WB
);

    state_e            state_q, state_d;
    logic              valid_wb_q, valid_wb_d;
    logic [DATA_W-1:0] result_wb_q, result_wb_d;
    logic [2:0]        rd_wb_q, rd_wb_d;
    logic              regwrite_wb_q, regwrite_wb_d;
    logic [2:0]        ld_rd_q, ld_rd_d;
    logic              ld_regwrite_q, ld_regwrite_d;

    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    logic is_read;
    logic is_write;

    assign mem_addr = AluResult_EXE[ADDR_W-1:0];
    assign is_write = signals_MEM[SIG_MEMWRITE];
    assign is_read  = signals_MEM[SIG_MEMREAD] && !signals_MEM[SIG_MEMWRITE];

    logic unused_ok;
    assign unused_ok = ^{signals_MEM[SIG_SPARE], AluResult_EXE[DATA_W-1:ADDR_W]};

    data_memory #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_data_memory (
        .clk   (clk),
        .addr  (mem_addr),
        .we    (mem_we),
        .wdata (valueB_EXE),
        .re    (mem_re),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d       = state_q;
        valid_wb_d    = 1'b0;
        regwrite_wb_d = 1'b0;
        result_wb_d   = result_wb_q;
        rd_wb_d       = rd_wb_q;
        ld_rd_d       = ld_rd_q;
        ld_regwrite_d = ld_regwrite_q;
        mem_we        = 1'b0;
        mem_re        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid_EXE && !flush) begin
                    if (is_write) begin
                        mem_we      = 1'b1;
                        valid_wb_d  = 1'b1;
                        result_wb_d = AluResult_EXE;
                        rd_wb_d     = rd_EXE;
                    end else if (is_read) begin
                        mem_re        = 1'b1;
                        ld_rd_d       = rd_EXE;
                        ld_regwrite_d = signals_MEM[SIG_REGWRITE];
                        state_d       = ST_LOAD_WAIT;
                    end else begin
                        valid_wb_d    = 1'b1;
                        regwrite_wb_d = signals_MEM[SIG_REGWRITE];
                        result_wb_d   = AluResult_EXE;
                        rd_wb_d       = rd_EXE;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                // Upstream is stalled here, so its inputs are never accepted on this edge.
                state_d = ST_IDLE;
                if (!flush) begin
                    valid_wb_d    = 1'b1;
                    regwrite_wb_d = ld_regwrite_q;
                    result_wb_d   = mem_rdata;
                    rd_wb_d       = ld_rd_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            valid_wb_q    <= 1'b0;
            result_wb_q   <= '0;
            rd_wb_q       <= '0;
            regwrite_wb_q <= 1'b0;
            ld_rd_q       <= '0;
            ld_regwrite_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            valid_wb_q    <= valid_wb_d;
            result_wb_q   <= result_wb_d;
            rd_wb_q       <= rd_wb_d;
            regwrite_wb_q <= regwrite_wb_d;
            ld_rd_q       <= ld_rd_d;
            ld_regwrite_q <= ld_regwrite_d;
        end
    end

    assign stall_MEM   = (state_q == ST_LOAD_WAIT);
    assign valid_WB    = valid_wb_q;
    assign result_WB   = result_wb_q;
    assign rd_WB       = rd_wb_q;
    assign RegWrite_WB = regwrite_wb_q;

endmodule : mem_stage

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : directed self-checking bench for mem_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

    localparam int DATA_W = 16;

    localparam logic [3:0] SIG_ALU   = 4'b0010;
    localparam logic [3:0] SIG_ST    = 4'b0100;
    localparam logic [3:0] SIG_LD    = 4'b1010;
    localparam logic [3:0] SIG_LDST  = 4'b1100;

    logic              clk;
    logic              reset_n;
    logic              valid_EXE;
    logic [DATA_W-1:0] AluResult_EXE;
    logic [DATA_W-1:0] valueB_EXE;
    logic [2:0]        rd_EXE;
    logic [3:0]        signals_MEM;
    logic              flush;
    logic              stall_MEM;
    logic              valid_WB;
    logic [DATA_W-1:0] result_WB;
    logic [2:0]        rd_WB;
    logic              RegWrite_WB;

    int checks;
    int errors;

    mem_stage dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .valid_EXE     (valid_EXE),
        .AluResult_EXE (AluResult_EXE),
        .valueB_EXE    (valueB_EXE),
        .rd_EXE        (rd_EXE),
        .signals_MEM   (signals_MEM),
        .flush         (flush),
        .stall_MEM     (stall_MEM),
        .valid_WB      (valid_WB),
        .result_WB     (result_WB),
        .rd_WB         (rd_WB),
        .RegWrite_WB   (RegWrite_WB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] b,
                         input logic [2:0] rd, input logic [3:0] sig, input logic fl);
        valid_EXE     = v;
        AluResult_EXE = alu;
        valueB_EXE    = b;
        rd_EXE        = rd;
        signals_MEM   = sig;
        flush         = fl;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 3'd0, 4'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_stall",  32'(stall_MEM),   32'd0);
        chk("rst_valid",  32'(valid_WB),    32'd0);
        chk("rst_result", 32'(result_WB),   32'd0);
        chk("rst_rd",     32'(rd_WB),       32'd0);
        chk("rst_rw",     32'(RegWrite_WB), 32'd0);

        // ALU op accepted on the very first edge after reset release
        reset_n = 1'b1;
        drive(1'b1, 16'hFFF6, 16'h0, 3'd5, SIG_ALU, 1'b0);
        step();
        chk("alu_valid",  32'(valid_WB),    32'd1);
        chk("alu_result", 32'(result_WB),   32'hFFF6);
        chk("alu_rd",     32'(rd_WB),       32'd5);
        chk("alu_rw",     32'(RegWrite_WB), 32'd1);
        chk("alu_stall",  32'(stall_MEM),   32'd0);

        // Bubble: WB fields hold, valid/RegWrite drop
        drive(1'b0, 16'h1111, 16'h0, 3'd1, SIG_ALU, 1'b0);
        step();
        chk("idle_valid",  32'(valid_WB),    32'd0);
        chk("idle_rw",     32'(RegWrite_WB), 32'd0);
        chk("idle_result", 32'(result_WB),   32'hFFF6);
        chk("idle_rd",     32'(rd_WB),       32'd5);

        // Store 0xBEEF to 0x0012, then load it back into r3
        drive(1'b1, 16'h0012, 16'hBEEF, 3'd1, SIG_ST, 1'b0);
        step();
        chk("st_valid", 32'(valid_WB),    32'd1);
        chk("st_rw",    32'(RegWrite_WB), 32'd0);
        chk("st_stall", 32'(stall_MEM),   32'd0);
        drive(1'b1, 16'h0012, 16'h0, 3'd3, SIG_LD, 1'b0);
        step();
        chk("ld_stall1", 32'(stall_MEM),   32'd1);
        chk("ld_valid1", 32'(valid_WB),    32'd0);
        chk("ld_rw1",    32'(RegWrite_WB), 32'd0);
        drive(1'b1, 16'h5555, 16'h0, 3'd6, SIG_ALU, 1'b0);
        step();
        chk("ld_stall2", 32'(stall_MEM),   32'd0);
        chk("ld_valid2", 32'(valid_WB),    32'd1);
        chk("ld_result", 32'(result_WB),   32'hBEEF);
        chk("ld_rd",     32'(rd_WB),       32'd3);
        chk("ld_rw2",    32'(RegWrite_WB), 32'd1);
        drive(1'b0, 16'h0, 16'h0, 3'd0, 4'b0, 1'b0);
        step();
        chk("ld_after_valid",  32'(valid_WB),  32'd0);
        chk("ld_after_result", 32'(result_WB), 32'hBEEF);

        // Address wrap: 0x0112 aliases 0x0012
        drive(1'b1, 16'h0112, 16'h1234, 3'd0, SIG_ST, 1'b0);
        step();
        drive(1'b1, 16'h0012, 16'h0, 3'd2, SIG_LD, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 3'd0, 4'b0, 1'b0);
        step();
        chk("wrap_result", 32'(result_WB), 32'h1234);
        chk("wrap_rd",     32'(rd_WB),     32'd2);

        // Flush during LOAD_WAIT drops the load
        drive(1'b1, 16'h0012, 16'h0, 3'd4, SIG_LD, 1'b0);
        step();
        chk("fl_stall1", 32'(stall_MEM), 32'd1);
        drive(1'b0, 16'h0, 16'h0, 3'd0, 4'b0, 1'b1);
        step();
        chk("fl_valid",  32'(valid_WB),    32'd0);
        chk("fl_rw",     32'(RegWrite_WB), 32'd0);
        chk("fl_stall2", 32'(stall_MEM),   32'd0);
        chk("fl_result", 32'(result_WB),   32'h1234);
        drive(1'b1, 16'h0042, 16'h0, 3'd7, SIG_ALU, 1'b0);
        step();
        chk("fl_alu_valid",  32'(valid_WB),    32'd1);
        chk("fl_alu_result", 32'(result_WB),   32'h0042);
        chk("fl_alu_rd",     32'(rd_WB),       32'd7);
        chk("fl_alu_rw",     32'(RegWrite_WB), 32'd1);

        // MemRead+MemWrite executes as a store only
        drive(1'b1, 16'h0007, 16'h00AA, 3'd1, SIG_LDST, 1'b0);
        step();
        chk("rw_stall", 32'(stall_MEM),   32'd0);
        chk("rw_valid", 32'(valid_WB),    32'd1);
        chk("rw_rw",    32'(RegWrite_WB), 32'd0);
        drive(1'b1, 16'h0007, 16'h0, 3'd1, SIG_LD, 1'b0);
        step();
        chk("rw_ld_stall", 32'(stall_MEM), 32'd1);
        drive(1'b0, 16'h0, 16'h0, 3'd0, 4'b0, 1'b0);
        step();
        chk("rw_ld_result", 32'(result_WB), 32'h00AA);
        chk("rw_ld_valid",  32'(valid_WB),  32'd1);

        // Flush in IDLE blocks acceptance
        drive(1'b1, 16'h9999, 16'h0, 3'd6, SIG_ALU, 1'b1);
        step();
        chk("fi_valid",  32'(valid_WB),    32'd0);
        chk("fi_rw",     32'(RegWrite_WB), 32'd0);
        chk("fi_result", 32'(result_WB),   32'h00AA);
        chk("fi_rd",     32'(rd_WB),       32'd1);

        // Async reset in the middle of LOAD_WAIT, no clock edge involved
        drive(1'b1, 16'h0012, 16'h0, 3'd5, SIG_LD, 1'b0);
        step();
        chk("ar_stall_pre", 32'(stall_MEM), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar_stall",  32'(stall_MEM),   32'd0);
        chk("ar_valid",  32'(valid_WB),    32'd0);
        chk("ar_result", 32'(result_WB),   32'h0000);
        chk("ar_rd",     32'(rd_WB),       32'd0);
        chk("ar_rw",     32'(RegWrite_WB), 32'd0);
        drive(1'b0, 16'h0, 16'h0, 3'd0, 4'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Memory contents survive reset
        drive(1'b1, 16'h0012, 16'h0, 3'd6, SIG_LD, 1'b0);
        step();
        chk("pr_stall", 32'(stall_MEM), 32'd1);
        drive(1'b0, 16'h0, 16'h0, 3'd0, 4'b0, 1'b0);
        step();
        chk("pr_result", 32'(result_WB), 32'h1234);
        chk("pr_rd",     32'(rd_WB),     32'd6);
        chk("pr_valid",  32'(valid_WB),  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_stage

`default_nettype wire
